// File: rtl/sensor_debounce.sv
// sensor_debounce: two-channel wall-sensor debouncer with 2-flop sync, hold freeze,
// one-cycle change events and a startup ready flag.
module sensor_debounce #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic head_raw,
  input  logic left_raw,
  input  logic hold,
  output logic head,
  output logic left,
  output logic head_evt,
  output logic left_evt,
  output logic ready
);
  localparam logic [7:0] C_LAST = 8'(DB_CYCLES - 1);
  localparam logic [8:0] C_RDY  = 9'(DB_CYCLES + 1);
  logic [8:0] r_start;
  logic       r_ready;
  logic       w_ready_nxt;
  logic [1:0] w_raw;
  logic [1:0] w_out;
  logic [1:0] w_evt;
  assign w_raw = {left_raw, head_raw};
  // Events are gated by the ready value that becomes visible on the same edge.
  assign w_ready_nxt = r_ready | (r_start == C_RDY);
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_start <= '0;
      r_ready <= 1'b0;
    end else if (!r_ready) begin
      r_start <= r_start + 9'd1;
      r_ready <= w_ready_nxt;
    end
  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic       r_s1, r_s2, r_out, r_evt;
    logic [7:0] r_cnt;
    always_ff @(posedge clock or negedge reset)
      if (!reset) begin
        r_s1  <= 1'b0;
        r_s2  <= 1'b0;
        r_out <= 1'b0;
        r_evt <= 1'b0;
        r_cnt <= '0;
      end else begin
        r_s1  <= w_raw[c];
        r_s2  <= r_s1;
        r_evt <= 1'b0;
        if (hold || r_s2 == r_out) r_cnt <= '0;
        else if (r_cnt == C_LAST) begin
          r_out <= r_s2;
          r_cnt <= '0;
          r_evt <= w_ready_nxt;
        end else r_cnt <= r_cnt + 8'd1;
      end
    assign w_out[c] = r_out;
    assign w_evt[c] = r_evt;
  end
  assign head     = w_out[0];
  assign left     = w_out[1];
  assign head_evt = w_evt[0];
  assign left_evt = w_evt[1];
  assign ready    = r_ready;
endmodule

// File: tb/tb_sensor_debounce.sv
// tb_sensor_debounce: randomized and directed checks of sensor_debounce against a
// run-length behavioural model of the debounce rules.
module tb_sensor_debounce;
  localparam int DB = 4;
  logic clock = 1'b0, reset = 1'b0, head_raw = 1'b0, left_raw = 1'b0, hold = 1'b0;
  logic head, left, head_evt, left_evt, ready;
  int checks = 0, failures = 0;
  bit m_s1 [2], m_s2 [2], m_out [2], m_evt [2];
  int m_run [2];
  int m_edges;

  sensor_debounce #(.DB_CYCLES(DB)) dut (
    .clock(clock), .reset(reset), .head_raw(head_raw), .left_raw(left_raw), .hold(hold),
    .head(head), .left(left), .head_evt(head_evt), .left_evt(left_evt), .ready(ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_s1[c] = 0; m_s2[c] = 0; m_out[c] = 0; m_evt[c] = 0; m_run[c] = 0;
    end
    m_edges = 0;
  endtask

  // An output flips only after DB consecutive non-hold edges whose synchronized
  // sample disagrees with it; the sync is a 2-deep delay line of raw samples.
  task automatic model_step();
    bit raw [2];
    bit rdy;
    raw[0] = head_raw; raw[1] = left_raw;
    m_edges++;
    rdy = (m_edges >= DB + 2);
    for (int c = 0; c < 2; c++) begin
      m_evt[c] = 0;
      if (hold || m_s2[c] == m_out[c]) m_run[c] = 0;
      else begin
        m_run[c]++;
        if (m_run[c] == DB) begin
          m_out[c] = m_s2[c];
          m_run[c] = 0;
          m_evt[c] = rdy;
        end
      end
      m_s2[c] = m_s1[c];
      m_s1[c] = raw[c];
    end
  endtask

  task automatic cyc(input bit h, input bit l, input bit hd);
    head_raw = h; left_raw = l; hold = hd;
    model_step();
    @(posedge clock);
    #2;
  endtask

  task automatic pulse_reset_release();
    reset = 1'b0;
    model_reset();
    #3;
    reset = 1'b1;
  endtask

  always @(posedge clock) begin
    #1;
    if (reset)
      chk("model_cmp", {4'd0, ready, left_evt, head_evt, left, head},
          {4'd0, bit'(m_edges >= DB + 2), m_evt[1], m_evt[0], m_out[1], m_out[0]});
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #2;
    chk("reset_outs", {4'd0, ready, left_evt, head_evt, left, head}, 9'd0);
    reset = 1'b1;
    // First change after reset: lands on edge 6 together with ready.
    for (int e = 1; e <= 5; e++) cyc(1, 0, 0);
    chk("head_before_e6", head, 0);
    chk("ready_before_e6", ready, 0);
    cyc(1, 0, 0);
    chk("head_at_e6", head, 1);
    chk("evt_at_e6", head_evt, 1);
    chk("ready_at_e6", ready, 1);
    cyc(1, 0, 0);
    chk("evt_after_e7", head_evt, 0);
    // Fall back to head=0 and settle.
    repeat (8) cyc(0, 0, 0);
    chk("head_settled0", head, 0);
    // Glitch of two raw cycles never reaches the output.
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    for (int e = 0; e < 8; e++) begin
      cyc(0, 0, 0);
      chk("glitch_head", {head, head_evt}, 2'b00);
    end
    // Simultaneous rise on both channels.
    repeat (5) cyc(1, 1, 0);
    chk("simul_before", {head, left}, 2'b00);
    cyc(1, 1, 0);
    chk("simul_outs", {head, left}, 2'b11);
    chk("simul_evts", {head_evt, left_evt}, 2'b11);
    repeat (8) cyc(0, 0, 0);
    // Hold freezes left for 10 edges, then DB more edges are needed.
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    for (int e = 0; e < 10; e++) begin
      cyc(0, 1, 1);
      chk("hold_left", {left, left_evt}, 2'b00);
    end
    repeat (DB - 1) cyc(0, 1, 0);
    chk("hold_release_pre", left, 0);
    cyc(0, 1, 0);
    chk("hold_release", {left, left_evt}, 2'b11);
    // Async reset mid-count discards progress and clears outputs at once.
    repeat (4) cyc(1, 1, 0);
    reset = 1'b0;
    #1;
    chk("async_reset", {4'd0, ready, left_evt, head_evt, left, head}, 9'd0);
    model_reset();
    #2;
    reset = 1'b1;
    repeat (5) cyc(1, 1, 0);
    chk("post_reset_pre", head, 0);
    cyc(1, 1, 0);
    chk("post_reset_rise", {head, head_evt, ready}, 3'b111);
    // Random toggling with occasional holds and rare resets.
    begin
      bit h = 0, l = 0;
      for (int i = 0; i < 10000; i++) begin
        if ($urandom_range(0, 6) == 0) h = ~h;
        if ($urandom_range(0, 6) == 0) l = ~l;
        if ($urandom_range(0, 1999) == 0) pulse_reset_release();
        cyc(h, l, $urandom_range(0, 24) == 0);
      end
    end
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
